// File: rtl/da2_pkg.sv
// Shared types and helpers for the Pmod DA2 dual-DAC serializer.
package da2_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned BIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] ch2;
        logic [DATA_W-1:0] ch1;
    } sample_pair_t;

    // DAC121S101 frame: two don't-care zeros, power-down mode, 12-bit code
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0]        pd,
                                                          input logic [DATA_W-1:0] data);
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/da2_bit_timer.sv
// SCLK phase generator: sclk_level is high for the first HALF_DIV cycles of each
// bit period, bit_tick marks the last cycle of a period. Both are registered.
module da2_bit_timer #(
    parameter int unsigned HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic sclk_level,
    output logic bit_tick
);

    localparam int unsigned PERIOD = 2 * HALF_DIV;
    localparam int unsigned PH_W   = $clog2(PERIOD);

    logic [PH_W-1:0] phase_q;
    logic [PH_W-1:0] phase_d;

    always_comb begin
        phase_d = '0;
        if (!clear && (phase_q != PH_W'(PERIOD - 1))) begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    // Outputs are decoded from the next phase so they line up with phase_q
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q    <= '0;
            sclk_level <= 1'b1;
            bit_tick   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            sclk_level <= (phase_d < PH_W'(HALF_DIV));
            bit_tick   <= (phase_d == PH_W'(PERIOD - 1));
        end
    end

endmodule

// File: rtl/pmod_da2_serializer.sv
// Serializes one 12-bit sample pair per valid/ready handshake onto the two data
// lines of a Pmod DA2 (dual DAC121S101), 16-bit frames MSB first, shared SCLK.
module pmod_da2_serializer
    import da2_pkg::*;
#(
    parameter int unsigned HALF_DIV = 1,
    parameter int unsigned GAP_CYC  = 2,
    parameter logic [1:0]  PD_MODE  = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              d1,
    output logic              d2,
    output logic              sclk,
    output logic              nsync,
    output logic              done
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t                 state_q;
    state_t                 state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q;
    logic [GAP_W-1:0]       gap_cnt_d;
    logic [FRAME_BITS-1:0]  sr1_q;
    logic [FRAME_BITS-1:0]  sr1_d;
    logic [FRAME_BITS-1:0]  sr2_q;
    logic [FRAME_BITS-1:0]  sr2_d;
    logic                   in_ready_d;
    logic                   nsync_d;
    logic                   done_d;
    logic                   bit_tick;
    logic                   timer_clear;
    sample_pair_t           pair;

    assign pair        = {data2, data1};
    assign timer_clear = (state_q != SHIFT);

    // Zeros shift in behind the frame, so the data lines rest low outside SHIFT
    assign d1 = sr1_q[FRAME_BITS-1];
    assign d2 = sr2_q[FRAME_BITS-1];

    da2_bit_timer #(
        .HALF_DIV (HALF_DIV)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .sclk_level (sclk),
        .bit_tick   (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    sr1_d     = build_frame(PD_MODE, pair.ch1);
                    sr2_d     = build_frame(PD_MODE, pair.ch2);
                end
            end
            SHIFT: begin
                // Shift on the cycle that also returns SCLK high
                if (bit_tick) begin
                    sr1_d = {sr1_q[FRAME_BITS-2:0], 1'b0};
                    sr2_d = {sr2_q[FRAME_BITS-2:0], 1'b0};
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        nsync_d    = (state_d != SHIFT);
        done_d     = (state_q == GAP) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            in_ready  <= 1'b1;
            nsync     <= 1'b1;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            in_ready  <= in_ready_d;
            nsync     <= nsync_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pmod_da2_serializer.sv
// Bench for pmod_da2_serializer: a default instance and a slow-SCLK/power-down
// instance, checked by a wire-level frame capture against expected frame words.
module tb_pmod_da2_serializer;

    localparam int unsigned HD_A  = 1;
    localparam int unsigned GAP_A = 2;
    localparam logic [1:0]  PD_A  = 2'b00;
    localparam int unsigned HD_B  = 3;
    localparam int unsigned GAP_B = 3;
    localparam logic [1:0]  PD_B  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] data1_a = '0, data2_a = '0, data1_b = '0, data2_b = '0;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic        in_ready_a, d1_a, d2_a, sclk_a, nsync_a, done_a;
    logic        in_ready_b, d1_b, d2_b, sclk_b, nsync_b, done_b;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmod_da2_serializer #(.HALF_DIV(HD_A), .GAP_CYC(GAP_A), .PD_MODE(PD_A)) dut_a (
        .clk(clk), .rst(rst), .data1(data1_a), .data2(data2_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .d1(d1_a), .d2(d2_a), .sclk(sclk_a), .nsync(nsync_a), .done(done_a)
    );

    pmod_da2_serializer #(.HALF_DIV(HD_B), .GAP_CYC(GAP_B), .PD_MODE(PD_B)) dut_b (
        .clk(clk), .rst(rst), .data1(data1_b), .data2(data2_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .d1(d1_b), .d2(d2_b), .sclk(sclk_b), .nsync(nsync_b), .done(done_b)
    );

    typedef struct packed {
        int          bits;
        logic [15:0] f1;
        logic [15:0] f2;
        int          low_len;
        int          high_len;
        int          gap_hold;
        int          last_fall;
        logic        prev_sclk;
        logic        prev_nsync;
    } mon_t;

    typedef struct packed {
        int          id;
        logic [15:0] f1;
        logic [15:0] f2;
        int          low_len;
        int          gap_before;
    } frame_t;

    typedef struct packed {
        int id;
        int cyc;
    } done_t;

    typedef struct packed {
        logic [11:0] d1;
        logic [11:0] d2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    frame_t frames_q[$];
    done_t  done_q[$];
    mon_t   mon_a, mon_b;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Expected DAC word: power-down bits above the 12-bit code
    function automatic logic [15:0] ref_frame(input logic [1:0] pd, input logic [11:0] d);
        return 16'(int'(pd) * 4096 + int'(d));
    endfunction

    // Wire-level receiver: shifts in data on each SCLK fall while nSYNC is low
    function automatic mon_t mon_step(input int id, input mon_t mi, input logic r, input logic ns,
                                      input logic sc, input logic b1, input logic b2,
                                      input logic dn, input int hd);
        mon_t   m;
        done_t  dv;
        frame_t fv;
        m = mi;
        if (r !== 1'b1) begin
            m = '0;
            m.prev_sclk  = 1'b1;
            m.prev_nsync = 1'b1;
            return m;
        end
        if (dn === 1'b1) begin
            dv.id  = id;
            dv.cyc = cyc;
            done_q.push_back(dv);
        end
        if (ns !== m.prev_nsync) check($sformatf("nsync_edge_sclk_high_%0d", id), 32'(sc), 32'd1);
        if (ns === 1'b0) begin
            if (m.prev_nsync === 1'b1) begin
                m.bits     = 0;
                m.low_len  = 0;
                m.f1       = '0;
                m.f2       = '0;
                m.gap_hold = m.high_len;
            end
            m.low_len = m.low_len + 1;
            if (m.prev_sclk === 1'b1 && sc === 1'b0) begin
                if (m.bits > 0) check($sformatf("sclk_fall_spacing_%0d", id), cyc - m.last_fall, 2 * hd);
                m.last_fall = cyc;
                m.f1        = {m.f1[14:0], b1};
                m.f2        = {m.f2[14:0], b2};
                m.bits      = m.bits + 1;
            end
        end else begin
            if (m.prev_nsync === 1'b0) begin
                check($sformatf("frame_fall_count_%0d", id), m.bits, 16);
                fv.id         = id;
                fv.f1         = m.f1;
                fv.f2         = m.f2;
                fv.low_len    = m.low_len;
                fv.gap_before = m.gap_hold;
                frames_q.push_back(fv);
                m.high_len = 0;
            end
            m.high_len = m.high_len + 1;
        end
        m.prev_sclk  = sc;
        m.prev_nsync = ns;
        return m;
    endfunction

    always @(negedge clk) begin
        mon_a = mon_step(0, mon_a, rst, nsync_a, sclk_a, d1_a, d2_a, done_a, HD_A);
        mon_b = mon_step(1, mon_b, rst, nsync_b, sclk_b, d1_b, d2_b, done_b, HD_B);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a pair; acc is the cycle counter value during the first cycle after accept
    task automatic send(input int id, input logic [11:0] a, input logic [11:0] b, output int acc);
        logic rdy;
        bit   got;
        got = 0;
        acc = -1;
        if (id == 0) begin data1_a = a; data2_a = b; in_valid_a = 1'b1; end
        else         begin data1_b = a; data2_b = b; in_valid_b = 1'b1; end
        for (int k = 0; k < 400 && !got; k++) begin
            rdy = (id == 0) ? in_ready_a : in_ready_b;
            tick();
            if (rdy === 1'b1) begin
                got = 1;
                acc = cyc;
            end
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic wait_done(input int id, output int dc);
        done_t d;
        dc = -1;
        for (int k = 0; k < 400 && dc < 0; k++) begin
            if (done_q.size() > 0) begin
                d  = done_q.pop_front();
                dc = d.cyc;
                check("done_source", d.id, id);
            end else begin
                tick();
            end
        end
        if (dc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input int id, input logic [15:0] e1,
                               input logic [15:0] e2, input int hd, output int gap);
        frame_t f;
        gap = -1;
        if (frames_q.size() == 0) begin
            check({tag, "_frame_missing"}, 0, 1);
            return;
        end
        f   = frames_q.pop_front();
        gap = f.gap_before;
        check({tag, "_id"}, f.id, id);
        check({tag, "_d1"}, f.f1, e1);
        check({tag, "_d2"}, f.f2, e2);
        check({tag, "_nsync_low"}, f.low_len, 32 * hd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int          acc, dc, gap, n_acc, ready_bad;
        int          accs[3];
        int          dcs[3];
        bit          seen;
        logic [11:0] r1, r2;

        // Reset with in_valid high: idle outputs, nothing taken
        rst = 1'b0; in_valid_a = 1'b1; in_valid_b = 1'b1;
        data1_a = 12'hFFF; data2_a = 12'hFFF; data1_b = 12'hABC; data2_b = 12'h123;
        repeat (3) begin
            tick();
            check("reset_outputs_a", {nsync_a, sclk_a, d1_a, d2_a, in_ready_a, done_a}, 6'b110010);
        end
        check("reset_outputs_b", {nsync_b, sclk_b, d1_b, d2_b, in_ready_b, done_b}, 6'b110010);
        in_valid_a = 1'b0; in_valid_b = 1'b0; rst = 1'b1;
        repeat (3) begin
            tick();
            check("post_reset_idle", {nsync_a, in_ready_a, nsync_b, in_ready_b}, 4'b1111);
        end

        // Single frames from a vector table, defaults instance
        vecs[0] = '{12'hA5C, 12'h3F0, 16'h0A5C, 16'h03F0};
        vecs[1] = '{12'h000, 12'hFFF, 16'h0000, 16'h0FFF};
        vecs[2] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000};
        vecs[3] = '{12'h800, 12'h7FF, 16'h0800, 16'h07FF};
        for (int i = 4; i < 8; i++) begin
            r1 = 12'($urandom_range(0, 4095));
            r2 = 12'($urandom_range(0, 4095));
            vecs[i] = '{r1, r2, ref_frame(PD_A, r1), ref_frame(PD_A, r2)};
        end
        for (int i = 0; i < 8; i++) begin
            send(0, vecs[i].d1, vecs[i].d2, acc);
            wait_done(0, dc);
            check($sformatf("vec%0d_latency", i), dc - acc + 1, 1 + 32 * HD_A + GAP_A);
            check_frame($sformatf("vec%0d", i), 0, vecs[i].e1, vecs[i].e2, HD_A, gap);
            repeat (2) tick();
        end

        // Back-to-back: in_valid held, pair accepted in each done cycle
        n_acc = 0;
        data1_a = 12'h000; data2_a = 12'h800; in_valid_a = 1'b1;
        for (int k = 0; k < 400 && n_acc < 3; k++) begin
            seen = in_ready_a;
            tick();
            if (seen) begin
                accs[n_acc] = cyc;
                n_acc = n_acc + 1;
                data1_a = 12'(n_acc);
                data2_a = 12'h800 + 12'(n_acc);
                if (n_acc == 3) in_valid_a = 1'b0;
            end
        end
        check("b2b_accepts", n_acc, 3);
        for (int i = 0; i < 3; i++) wait_done(0, dcs[i]);
        check("b2b_done_spacing1", dcs[1] - dcs[0], 1 + 32 * HD_A + GAP_A);
        check("b2b_done_spacing2", dcs[2] - dcs[1], 1 + 32 * HD_A + GAP_A);
        check("b2b_accept_spacing", accs[2] - accs[1], 1 + 32 * HD_A + GAP_A);
        for (int i = 0; i < 3; i++) begin
            check_frame($sformatf("b2b%0d", i), 0, ref_frame(PD_A, 12'(i)),
                        ref_frame(PD_A, 12'h800 + 12'(i)), HD_A, gap);
            if (i > 0) check($sformatf("b2b%0d_nsync_high", i), gap, GAP_A + 1);
        end
        repeat (3) tick();

        // Slow SCLK with power-down bits set
        r2 = 12'($urandom_range(0, 4095));
        send(1, 12'hFFF, r2, acc);
        wait_done(1, dc);
        check("slow_latency", dc - acc + 1, 1 + 32 * HD_B + GAP_B);
        check_frame("slow", 1, 16'h3FFF, ref_frame(PD_B, r2), HD_B, gap);
        repeat (3) tick();

        // Reset after bit 7 aborts the frame without a done
        send(0, 12'h5A5, 12'h0F0, acc);
        for (int k = 0; k < 200 && mon_a.bits < 8; k++) tick();
        check("midrst_reached_bit7", mon_a.bits, 8);
        rst = 1'b0;
        tick();
        check("midrst_outputs", {nsync_a, sclk_a, d1_a, d2_a, in_ready_a, done_a}, 6'b110010);
        rst = 1'b1;
        repeat (60) tick();
        check("midrst_no_done", done_q.size(), 0);
        check("midrst_no_frame", frames_q.size(), 0);
        send(0, 12'h3C3, 12'hC3C, acc);
        wait_done(0, dc);
        check("after_rst_latency", dc - acc + 1, 1 + 32 * HD_A + GAP_A);
        check_frame("after_rst", 0, 16'h03C3, 16'h0C3C, HD_A, gap);
        repeat (3) tick();

        // Inputs changing and in_valid pulsing mid-frame are ignored
        send(0, 12'h123, 12'h456, acc);
        ready_bad = 0;
        seen = 0;
        for (int k = 2; k < 200 && !seen; k++) begin
            tick();
            if (k == 2)  data1_a = 12'hFFF;
            if (k == 3)  in_valid_a = 1'b1;
            if (k == 20) in_valid_a = 1'b0;
            if (done_q.size() > 0) seen = 1;
            else if (in_ready_a !== 1'b0) ready_bad = ready_bad + 1;
        end
        check("stab_ready_low_in_frame", ready_bad, 0);
        check("stab_ready_at_done", 32'(in_ready_a), 32'd1);
        wait_done(0, dc);
        check("stab_latency", dc - acc + 1, 1 + 32 * HD_A + GAP_A);
        check_frame("stab", 0, 16'h0123, 16'h0456, HD_A, gap);
        repeat (40) tick();
        check("stab_no_extra_frame", frames_q.size() + done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
